// File: rtl/mont_mult_serial_pkg.sv
// Shared types and constants for the bit-serial Montgomery multiplier.
// Default modulus is the NIST P-192 prime.
package mont_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      CORR = 2'd2,
      DONE = 2'd3
   } mont_state_t;

   localparam int DEF_WIDTH = 192;
   localparam logic [DEF_WIDTH-1:0] P192 =
      192'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFFFF_FFFFFFFF;

   // Bit-counter width able to index every multiplicand bit.
   function automatic int cnt_w(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/mont_mult_serial_step.sv
// One radix-2 Montgomery iteration: (acc + xbit*yr [+ m if odd]) / 2.
// Purely combinational so wider-radix or unrolled variants can chain copies.
module mont_step #(
   parameter int WIDTH = 192
) (
   input  logic [WIDTH+1:0] acc,
   input  logic [WIDTH-1:0] yr,
   input  logic             xbit,
   input  logic [WIDTH-1:0] m,
   output logic [WIDTH+1:0] acc_next
);

   logic [WIDTH+2:0] sum_s;
   logic [WIDTH+2:0] tot_s;

   // Add the selected partial product, then make the sum even with m before halving.
   always_comb begin
      sum_s = {1'b0, acc} + (xbit ? {3'b000, yr} : {(WIDTH+3){1'b0}});
      if (sum_s[0]) begin
         tot_s = sum_s + {3'b000, m};
      end else begin
         tot_s = sum_s;
      end
      acc_next = (WIDTH+2)'(tot_s >> 1);
   end

endmodule

// File: rtl/mont_mult_serial.sv
// Bit-serial radix-2 Montgomery multiplier: z = x*y*2^-WIDTH mod MODULUS.
// Start is edge-triggered in IDLE; done1 pulses once per result.
module mont_mult_serial
   import mont_pkg::*;
#(
   parameter int                WIDTH   = DEF_WIDTH,
   parameter logic [WIDTH-1:0]  MODULUS = WIDTH'(P192)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             start,
   output logic [WIDTH-1:0] z,
   output logic             done1,
   output logic             busy
);

   localparam int              CNT_W    = cnt_w(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   if (MODULUS[0] == 1'b0) begin : g_even_modulus
      $error("mont_mult_serial: MODULUS must be odd");
   end
   if (WIDTH < 4) begin : g_narrow_width
      $error("mont_mult_serial: WIDTH must be at least 4");
   end

   mont_state_t      state_q, state_d;
   logic             start_q;
   logic [WIDTH-1:0] xr_q, xr_d;
   logic [WIDTH-1:0] yr_q, yr_d;
   logic [WIDTH+1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] z_q, z_d;
   logic             done1_q, done1_d;
   logic             busy_q, busy_d;
   logic             req_s;
   logic [WIDTH+1:0] acc_step_s;
   logic [WIDTH+1:0] acc_sub_s;

   assign req_s     = start & ~start_q;
   assign acc_sub_s = acc_q - {2'b00, MODULUS};

   mont_step #(.WIDTH(WIDTH)) u_step (
      .acc      (acc_q),
      .yr       (yr_q),
      .xbit     (xr_q[cnt_q]),
      .m        (MODULUS),
      .acc_next (acc_step_s)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req_s) state_d = MULT;
            else       state_d = IDLE;
         end
         MULT: begin
            if (cnt_q == CNT_LAST) state_d = CORR;
            else                   state_d = MULT;
         end
         CORR:    state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and output next values; acc < 2M keeps the correction to one subtract.
   always_comb begin
      xr_d  = xr_q;
      yr_d  = yr_q;
      acc_d = acc_q;
      cnt_d = cnt_q;
      z_d   = z_q;
      case (state_q)
         IDLE: begin
            if (req_s) begin
               xr_d  = x;
               yr_d  = y;
               acc_d = '0;
               cnt_d = '0;
            end else begin
               acc_d = acc_q;
            end
         end
         MULT: begin
            acc_d = acc_step_s;
            cnt_d = cnt_q + CNT_W'(1);
         end
         CORR: begin
            if (acc_q >= {2'b00, MODULUS}) z_d = WIDTH'(acc_sub_s);
            else                           z_d = WIDTH'(acc_q);
         end
         DONE:    z_d = z_q;
         default: z_d = z_q;
      endcase
      busy_d  = (state_d == MULT) || (state_d == CORR);
      done1_d = (state_q == CORR);
   end

   // Datapath and registered-output flops.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         start_q <= 1'b0;
         xr_q    <= '0;
         yr_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         z_q     <= '0;
         done1_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         start_q <= start;
         xr_q    <= xr_d;
         yr_q    <= yr_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         z_q     <= z_d;
         done1_q <= done1_d;
         busy_q  <= busy_d;
      end
   end

   assign z     = z_q;
   assign done1 = done1_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_mont_mult_serial.sv
// Directed bench: WIDTH=8 / M=251 vectors (R^-1 mod M = 201) plus one P-192 multiply.
module tb_mont_mult_serial;

   logic         clk = 1'b0;
   logic         reset;
   logic [7:0]   x8, y8, z8;
   logic         start8, done8, busy8;
   logic [191:0] xw, yw, zw;
   logic         startw, donew, busyw;

   int           n_checks = 0;
   int           n_fail   = 0;
   logic [7:0]   prev_z;

   always #5 clk = ~clk;

   mont_mult_serial #(.WIDTH(8), .MODULUS(8'hFB)) u_dut8 (
      .clk   (clk),
      .reset (reset),
      .x     (x8),
      .y     (y8),
      .start (start8),
      .z     (z8),
      .done1 (done8),
      .busy  (busy8)
   );

   mont_mult_serial u_dutw (
      .clk   (clk),
      .reset (reset),
      .x     (xw),
      .y     (yw),
      .start (startw),
      .z     (zw),
      .done1 (donew),
      .busy  (busyw)
   );

   task automatic check_eq(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Runs one 8-bit multiply starting at the current negedge; start stays high afterwards
   // for the whole window so any retrigger would show up as a second pulse.
   task automatic run_op8(input string tag, input logic [7:0] xa, input logic [7:0] ya,
                          input logic [7:0] ez, input bit poke);
      int done_at = 0;
      int pulses  = 0;
      int busy_n  = 0;
      x8     = xa;
      y8     = ya;
      start8 = 1'b1;
      for (int k = 1; k <= 25; k++) begin
         @(negedge clk);
         if (done8) begin
            pulses++;
            if (done_at == 0) done_at = k;
         end
         if (busy8) busy_n++;
         if (k == 9)  check_eq({tag, " z_held"}, z8, prev_z);
         if (k == 10) check_eq({tag, " z"}, z8, ez);
         if (poke && k == 2) start8 = 1'b0;
         if (poke && k == 3) begin
            start8 = 1'b1;
            x8     = 8'hF7;
            y8     = 8'h0A;
         end
      end
      check_eq({tag, " latency"}, done_at, 10);
      check_eq({tag, " pulses"}, pulses, 1);
      check_eq({tag, " busy_cycles"}, busy_n, 9);
      start8 = 1'b0;
      prev_z = ez;
      @(negedge clk);
   endtask

   initial begin
      int pulses;
      int done_at;
      logic [191:0] z_at_done;

      reset  = 1'b0;
      start8 = 1'b0;
      startw = 1'b0;
      x8     = 8'h00;
      y8     = 8'h00;
      xw     = 192'd0;
      yw     = 192'd0;
      prev_z = 8'h00;

      repeat (2) @(negedge clk);
      check_eq("rst z8", z8, 8'h00);
      check_eq("rst done8", done8, 1'b0);
      check_eq("rst busy8", busy8, 1'b0);
      check_eq("rst zw", zw, 192'd0);
      check_eq("rst donew", donew, 1'b0);
      check_eq("rst busyw", busyw, 1'b0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      run_op8("f7x0a", 8'hF7, 8'h0A, 8'hF3, 1'b0);

      // Abort mid-MULT, keep start high through reset so release acts as a request.
      x8     = 8'hF7;
      y8     = 8'h0A;
      start8 = 1'b1;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      #1;
      check_eq("abort z", z8, 8'h00);
      check_eq("abort busy", busy8, 1'b0);
      check_eq("abort done", done8, 1'b0);
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (done8) pulses++;
      end
      check_eq("abort no_done", pulses, 0);
      reset  = 1'b1;
      prev_z = 8'h00;
      run_op8("rerun", 8'hF7, 8'h0A, 8'hF3, 1'b0);

      run_op8("d4x30", 8'hD4, 8'h30, 8'hE4, 1'b0);
      run_op8("faxfa", 8'hFA, 8'hFA, 8'hC9, 1'b0);
      run_op8("1x5", 8'h01, 8'h05, 8'h01, 1'b0);
      run_op8("0x30", 8'h00, 8'h30, 8'h00, 1'b0);
      run_op8("poke", 8'hD4, 8'h30, 8'hE4, 1'b1);

      // P-192: 2^191 * 48 * 2^-192 = 24.
      xw        = 192'd1 << 191;
      yw        = 192'd48;
      startw    = 1'b1;
      done_at   = 0;
      z_at_done = 192'd0;
      for (int k = 1; k <= 200; k++) begin
         @(negedge clk);
         if (donew && done_at == 0) begin
            done_at   = k;
            z_at_done = zw;
         end
      end
      check_eq("p192 latency", done_at, 194);
      check_eq("p192 z", z_at_done, 192'd24);
      startw = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
